// File: rtl/pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_ctrl
// Purpose  : Retunes the video PLL between NTSC and PAL fractional-K settings
//            through the reconfiguration core's management port, then waits
//            for the PLL to drop and regain lock.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_ctrl #(
    parameter logic [31:0] K_NTSC       = 32'd2532450157,
    parameter logic [31:0] K_PAL        = 32'd2201376898,
    parameter logic [19:0] LOCK_TIMEOUT = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pal,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    output logic        busy,
    output logic        done,
    output logic        lock_err,
    output logic        cur_pal
);

    localparam logic [2:0] c_idle        = 3'd0;
    localparam logic [2:0] c_wr_mode     = 3'd1;
    localparam logic [2:0] c_wr_k        = 3'd2;
    localparam logic [2:0] c_wr_start    = 3'd3;
    localparam logic [2:0] c_wait_unlock = 3'd4;
    localparam logic [2:0] c_wait_lock   = 3'd5;

    localparam logic [5:0]  c_addr_mode  = 6'h00;
    localparam logic [5:0]  c_addr_k     = 6'h07;
    localparam logic [5:0]  c_addr_start = 6'h02;
    localparam logic [19:0] c_unlock_last  = 20'd15;
    localparam logic [19:0] c_timeout_last = LOCK_TIMEOUT - 20'd1;

    logic [2:0]  r_state;
    logic        r_gap;
    logic [19:0] r_cnt;
    logic        r_target;
    logic        r_cur_pal;
    logic        r_lock_err;

    logic        w_in_wr;
    logic        w_write;
    logic        w_timeout;
    logic        w_finish;
    logic [2:0]  w_next_wr;
    logic [5:0]  w_addr;
    logic [31:0] w_data;

    // r_gap marks the mandatory idle cycle after an accepted write
    assign w_in_wr   = (r_state == c_wr_mode) || (r_state == c_wr_k) ||
                       (r_state == c_wr_start);
    assign w_write   = w_in_wr && !r_gap;
    assign w_timeout = (r_cnt == c_timeout_last);
    assign w_finish  = (r_state == c_wait_lock) && (pll_locked || w_timeout);

    always_comb begin
        w_next_wr = c_wait_unlock;
        w_addr    = 6'h00;
        w_data    = 32'd0;
        case (r_state)
            c_wr_mode: begin
                w_next_wr = c_wr_k;
                w_addr    = c_addr_mode;
            end
            c_wr_k: begin
                w_next_wr = c_wr_start;
                w_addr    = c_addr_k;
                w_data    = r_target ? K_PAL : K_NTSC;
            end
            c_wr_start: begin
                w_next_wr = c_wait_unlock;
                w_addr    = c_addr_start;
            end
            default: begin
                w_next_wr = c_wait_unlock;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_idle;
            r_gap      <= 1'b0;
            r_cnt      <= 20'd0;
            r_target   <= 1'b0;
            r_cur_pal  <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_cnt <= 20'd0;
                    if (pal != r_cur_pal) begin
                        r_target   <= pal;
                        r_lock_err <= 1'b0;
                        r_gap      <= 1'b0;
                        r_state    <= c_wr_mode;
                    end
                end
                c_wr_mode, c_wr_k, c_wr_start: begin
                    if (r_gap) begin
                        r_gap   <= 1'b0;
                        r_cnt   <= 20'd0;
                        r_state <= w_next_wr;
                    end else if (!mgmt_waitrequest) begin
                        r_gap <= 1'b1;
                    end
                end
                c_wait_unlock: begin
                    // A PLL that never visibly drops lock is still given 16 cycles
                    if (!pll_locked || (r_cnt == c_unlock_last)) begin
                        r_cnt   <= 20'd0;
                        r_state <= c_wait_lock;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                c_wait_lock: begin
                    if (w_finish) begin
                        r_cur_pal <= r_target;
                        r_cnt     <= 20'd0;
                        r_state   <= c_idle;
                        if (!pll_locked) begin
                            r_lock_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_gap   <= 1'b0;
                    r_cnt   <= 20'd0;
                end
            endcase
        end
    end

    assign mgmt_write     = w_write;
    assign mgmt_read      = 1'b0;
    assign mgmt_address   = w_write ? w_addr : 6'h00;
    assign mgmt_writedata = w_write ? w_data : 32'd0;
    assign busy           = (r_state != c_idle);
    assign done           = w_finish;
    assign lock_err       = r_lock_err;
    assign cur_pal        = r_cur_pal;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pll_reconfig_ctrl
// Purpose  : Self-checking bench for pll_reconfig_ctrl (table of reconfig
//            scenarios, write scoreboard, reset corner sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_ctrl;

    localparam logic [31:0] c_k_ntsc = 32'd2532450157;
    localparam logic [31:0] c_k_pal  = 32'd2201376898;

    typedef struct {
        logic        pal;
        int          stall;
        int          drop;
        int          relock;
        int          toggle_at;
        logic [31:0] k;
        int          exp_dly;
        logic        exp_cur;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pal;
    logic        pll_locked;
    logic        mgmt_waitrequest;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic        busy;
    logic        done;
    logic        lock_err;
    logic        cur_pal;

    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  sb[$];
    vec_t tbl[7];

    pll_reconfig_ctrl #(
        .LOCK_TIMEOUT(20'd100)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pal              (pal),
        .pll_locked       (pll_locked),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .busy             (busy),
        .done             (done),
        .lock_err         (lock_err),
        .cur_pal          (cur_pal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Runs one reconfiguration; the bench also plays the PLL (lock drop/relock)
    task automatic run_seq(input vec_t v, output int dones, output int dly, output int lat,
                           output int viol, output int kcyc, output logic cp,
                           output logic bz, output logic le);
        int          s;
        int          fb;
        int          stall_used;
        bit          fin;
        logic [31:0] kdata;
        wr_t         e;
        s = -1; fb = -1; dones = 0; dly = -1; viol = 0; kcyc = 0;
        stall_used = 0; fin = 1'b0; kdata = 32'd0;
        sb.push_back('{6'h00, 32'd0});
        sb.push_back('{6'h07, v.k});
        sb.push_back('{6'h02, 32'd0});
        for (int i = 0; i < 400 && !fin; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) pal = v.pal;
            if (s >= 0 && dones == 0) begin
                if (i - s == v.drop) pll_locked = 1'b0;
                if (i - s == v.drop + v.relock) pll_locked = 1'b1;
                if (i - s == v.toggle_at) pal = ~v.pal;
            end
            if (dones > 0) begin
                pll_locked = 1'b1;
                fin = 1'b1;
            end
            mgmt_waitrequest = mgmt_write && (mgmt_address == 6'h07) && (stall_used < v.stall);
            if (mgmt_waitrequest) stall_used++;
            #1;
            if (mgmt_read || (!mgmt_write && (mgmt_address != 6'h00 || mgmt_writedata != 32'd0))
                || (done && !busy)) viol++;
            if (busy && fb < 0) fb = i;
            if (mgmt_write && mgmt_address == 6'h07) begin
                if (kcyc == 0) kdata = mgmt_writedata;
                else if (mgmt_writedata !== kdata) viol++;
                kcyc++;
            end
            if (mgmt_write && !mgmt_waitrequest) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", {58'd0, mgmt_address}, 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", {58'd0, mgmt_address}, {58'd0, e.addr});
                    check("wr_data", {32'd0, mgmt_writedata}, {32'd0, e.data});
                end
                if (mgmt_address == 6'h02) s = i;
            end
            if (done) begin
                dones++;
                if (dones == 1 && s >= 0) dly = i - s;
            end
        end
        if (!fin) check("seq_no_completion", 64'd0, 64'd1);
        lat = s - fb;
        cp  = cur_pal;
        bz  = busy;
        le  = lock_err;
        mgmt_waitrequest = 1'b0;
    endtask

    task automatic run_row(input string tag, input vec_t v);
        int   dones, dly, lat, viol, kcyc;
        logic cp, bz, le;
        run_seq(v, dones, dly, lat, viol, kcyc, cp, bz, le);
        check({tag, "_done_count"}, 64'(dones), 64'd1);
        check({tag, "_done_delay"}, 64'(dly), 64'(v.exp_dly));
        check({tag, "_start_latency"}, 64'(lat), 64'(4 + v.stall));
        check({tag, "_protocol_viol"}, 64'(viol), 64'd0);
        check({tag, "_k_write_cycles"}, 64'(kcyc), 64'(v.stall + 1));
        check({tag, "_cur_pal"}, {63'd0, cp}, {63'd0, v.exp_cur});
        check({tag, "_busy_after"}, {63'd0, bz}, 64'd0);
        check({tag, "_lock_err"}, {63'd0, le}, {63'd0, v.exp_err});
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idle_bad;
        bit   found;
        // pal, stall, drop, relock, toggle_at, k, exp_dly, exp_cur, exp_err
        tbl[0] = '{1'b1, 0, 3,   50, -1, c_k_pal,   53, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 5, 3,   20, -1, c_k_ntsc,  23, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 0, 1, 1000, -1, c_k_pal,  102, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 2, 20,  10, -1, c_k_ntsc,  18, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 0, 3,   30,  8, c_k_pal,   33, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 0, 3,   10, -1, c_k_ntsc,  13, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 0, 3,   10, -1, c_k_pal,   13, 1'b1, 1'b0};

        reset = 1'b1; pal = 1'b0; pll_locked = 1'b1; mgmt_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_write", {63'd0, mgmt_write}, 64'd0);
        check("rst_read", {63'd0, mgmt_read}, 64'd0);
        check("rst_addr_data", {26'd0, mgmt_address, mgmt_writedata}, 64'd0);
        check("rst_status", {60'd0, busy, done, lock_err, cur_pal}, 64'd0);

        reset = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (busy || done || mgmt_write || mgmt_read) idle_bad++;
        end
        check("idle_100_cycles", 64'(idle_bad), 64'd0);

        for (int r = 0; r < 6; r++) begin
            run_row($sformatf("row%0d", r), tbl[r]);
        end

        // Reset while the K write is on the bus, then a clean restart
        @(posedge clk);
        #1;
        pal = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            if (mgmt_write && mgmt_address == 6'h07) found = 1'b1;
        end
        check("midwr_reached_wr_k", {63'd0, found}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("midwr_write_dropped", {63'd0, mgmt_write}, 64'd0);
        check("midwr_outputs_zero",
              {20'd0, mgmt_address, mgmt_writedata, mgmt_read, busy, done, lock_err, cur_pal}, 64'd0);
        reset = 1'b0;
        run_row("restart", tbl[6]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
